// File: rtl/key_conditioner.sv
// Push-button front end: per-key synchroniser and debouncer, then an arbiter
// that issues at most one registered command pulse per press-release episode.
module key_conditioner #(
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned CW              = 20
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_large,
   input  logic btn_seven,
   input  logic btn_small,
   input  logic btn_deck,
   input  logic btn_back,
   output logic large_add,
   output logic seven_add,
   output logic small_add,
   output logic deck_add,
   output logic back,
   output logic busy,
   output logic multi_err
);

   localparam int unsigned NB = 5;
   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] HOLD = 1'b1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [NB-1:0]                   raw;
   logic [SYNC_STAGES-1:0][NB-1:0]  chain;
   logic [NB-1:0]                   sync;
   logic [NB-1:0]                   deb;
   logic [NB-1:0][CW-1:0]           cnt;
   logic [0:0]                      state;
   logic [NB-1:0]                   cmd;
   logic                            single;

   assign raw  = {btn_back, btn_deck, btn_small, btn_seven, btn_large};
   assign sync = chain[SYNC_STAGES-1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         chain <= '0;
      end else begin
         chain <= {chain[SYNC_STAGES-2:0], raw};
      end
   end

   // Counter only runs while the synchronised level disagrees with the accepted one.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         deb <= '0;
         cnt <= '0;
      end else begin
         for (int unsigned i = 0; i < NB; i++) begin
            if (sync[i] == deb[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == CNT_LAST) begin
               deb[i] <= sync[i];
               cnt[i] <= '0;
            end else begin
               cnt[i] <= cnt[i] + CW'(1);
            end
         end
      end
   end

   assign single = (deb != '0) && ((deb & (deb - 5'd1)) == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cmd       <= '0;
         multi_err <= 1'b0;
      end else begin
         cmd       <= '0;
         multi_err <= 1'b0;
         case (state)
            IDLE: begin
               if (deb != '0) begin
                  state <= HOLD;
                  if (single) cmd       <= deb;
                  else        multi_err <= 1'b1;
               end
            end
            HOLD: begin
               if (deb == '0) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign large_add = cmd[0];
   assign seven_add = cmd[1];
   assign small_add = cmd[2];
   assign deck_add  = cmd[3];
   assign back      = cmd[4];
   assign busy      = (state == HOLD);

endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner: directed scenarios plus random key activity,
// all checked cycle by cycle against a rule-level reference model.
module tb_key_conditioner;

   localparam int unsigned S  = 2;
   localparam int unsigned D  = 8;
   localparam int unsigned CW = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [4:0] btn = '0;
   logic       large_add, seven_add, small_add, deck_add, back, busy, multi_err;
   logic [4:0] cmds;

   int vectors = 0;
   int miscompares = 0;

   key_conditioner #(.SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .CW(CW)) dut (
      .clk(clk), .rst(rst),
      .btn_large(btn[0]), .btn_seven(btn[1]), .btn_small(btn[2]),
      .btn_deck(btn[3]), .btn_back(btn[4]),
      .large_add(large_add), .seven_add(seven_add), .small_add(small_add),
      .deck_add(deck_add), .back(back), .busy(busy), .multi_err(multi_err)
   );

   assign cmds = {back, deck_add, small_add, seven_add, large_add};

   always #5 clk = ~clk;

   // Reference model. The accepted level follows the synchronised level once
   // that level has been seen unchanged for D consecutive edges.
   logic [4:0] m_line [S-1];
   logic [4:0] m_sync, m_deb, m_last, m_cmd;
   int         m_stable [5];
   logic       m_hold, m_merr;

   always @(posedge clk or posedge rst) begin : model
      logic [4:0] n_cmd, n_deb, n_last;
      logic       n_hold, n_merr;
      int         n_stable [5];
      int         pressed;
      if (rst) begin
         for (int k = 0; k < S - 1; k++) m_line[k] <= '0;
         m_sync <= '0; m_deb <= '0; m_last <= '0; m_cmd <= '0;
         m_hold <= 1'b0; m_merr <= 1'b0;
         for (int k = 0; k < 5; k++) m_stable[k] <= 0;
      end else begin
         n_cmd = '0; n_merr = 1'b0; n_hold = m_hold;
         pressed = $countones(m_deb);
         if (!m_hold) begin
            if (pressed == 1) begin n_cmd = m_deb; n_hold = 1'b1; end
            else if (pressed > 1) begin n_merr = 1'b1; n_hold = 1'b1; end
         end else if (pressed == 0) begin
            n_hold = 1'b0;
         end
         n_deb = m_deb; n_last = m_last;
         for (int k = 0; k < 5; k++) begin
            if (m_sync[k] == m_last[k]) n_stable[k] = m_stable[k] + 1;
            else begin n_last[k] = m_sync[k]; n_stable[k] = 1; end
            if (n_stable[k] >= D && n_deb[k] != m_sync[k]) n_deb[k] = m_sync[k];
         end
         m_cmd <= n_cmd; m_merr <= n_merr; m_hold <= n_hold;
         m_deb <= n_deb; m_last <= n_last;
         for (int k = 0; k < 5; k++) m_stable[k] <= n_stable[k];
         m_sync <= m_line[0];
         for (int k = 0; k < S - 2; k++) m_line[k] <= m_line[k+1];
         m_line[S-2] <= btn;
      end
   end

   task automatic test_reset();
      #1;
      vectors++;
      if ({busy, multi_err, cmds} !== 7'b0) begin
         miscompares++;
         $display("FAIL reset_async: got %b required 0000000", {busy, multi_err, cmds});
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      vectors++;
      if ({busy, multi_err, cmds} !== 7'b0) begin
         miscompares++;
         $display("FAIL reset_held: got %b required 0000000", {busy, multi_err, cmds});
      end
      rst = 1'b0;
   endtask

   task automatic test_clean_press();
      int pulses = 0;
      for (int c = 0; c < 75; c++) begin
         @(negedge clk);
         vectors++;
         if ({busy, multi_err, cmds} !== {m_hold, m_merr, m_cmd}) begin
            miscompares++;
            $display("FAIL clean_press model cyc %0d: got %b required %b", c, {busy, multi_err, cmds}, {m_hold, m_merr, m_cmd});
         end
         if (small_add) pulses++;
         if (c == 11 || c == 50 || c == 51) begin
            vectors++;
            if ({busy, small_add} !== ((c == 11) ? 2'b11 : (c == 50) ? 2'b10 : 2'b00)) begin
               miscompares++;
               $display("FAIL clean_press timing cyc %0d: busy,small got %b", c, {busy, small_add});
            end
         end
         if (c == 0)  btn[2] = 1'b1;
         if (c == 40) btn[2] = 1'b0;
      end
      vectors++;
      if (pulses != 1) begin
         miscompares++;
         $display("FAIL clean_press count: got %0d pulses required 1", pulses);
      end
   endtask

   task automatic test_bounce();
      int pulses = 0;
      for (int c = 0; c < 75; c++) begin
         @(negedge clk);
         vectors++;
         if ({busy, multi_err, cmds} !== {m_hold, m_merr, m_cmd}) begin
            miscompares++;
            $display("FAIL bounce model cyc %0d: got %b required %b", c, {busy, multi_err, cmds}, {m_hold, m_merr, m_cmd});
         end
         if (large_add) pulses++;
         if (c == 21) begin
            vectors++;
            if (large_add !== 1'b1) begin
               miscompares++;
               $display("FAIL bounce timing: large_add got %b required 1 at cyc 21", large_add);
            end
         end
         btn[0] = (c < 3) || (c >= 5 && c < 9) || (c >= 10 && c < 40);
      end
      vectors++;
      if (pulses != 1) begin
         miscompares++;
         $display("FAIL bounce count: got %0d pulses required 1", pulses);
      end
   endtask

   task automatic test_simultaneous();
      int pulses = 0;
      for (int c = 0; c < 70; c++) begin
         @(negedge clk);
         vectors++;
         if ({busy, multi_err, cmds} !== {m_hold, m_merr, m_cmd}) begin
            miscompares++;
            $display("FAIL simultaneous model cyc %0d: got %b required %b", c, {busy, multi_err, cmds}, {m_hold, m_merr, m_cmd});
         end
         pulses += $countones(cmds);
         if (c == 11 || c == 45 || c == 46) begin
            vectors++;
            if ({busy, multi_err} !== ((c == 11) ? 2'b11 : (c == 45) ? 2'b10 : 2'b00)) begin
               miscompares++;
               $display("FAIL simultaneous timing cyc %0d: busy,multi_err got %b", c, {busy, multi_err});
            end
         end
         if (c == 0)  btn = 5'b10010;
         if (c == 30) btn[1] = 1'b0;
         if (c == 35) btn[4] = 1'b0;
      end
      vectors++;
      if (pulses != 0) begin
         miscompares++;
         $display("FAIL simultaneous cmds: got %0d command pulses required 0", pulses);
      end
   endtask

   task automatic test_overlap();
      int deck_n = 0, small_n = 0, err_n = 0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         vectors++;
         if ({busy, multi_err, cmds} !== {m_hold, m_merr, m_cmd}) begin
            miscompares++;
            $display("FAIL overlap model cyc %0d: got %b required %b", c, {busy, multi_err, cmds}, {m_hold, m_merr, m_cmd});
         end
         deck_n += int'(deck_add); small_n += int'(small_add); err_n += int'(multi_err);
         if (c == 11 || c == 61) begin
            vectors++;
            if ({deck_add, small_add} !== ((c == 11) ? 2'b10 : 2'b01)) begin
               miscompares++;
               $display("FAIL overlap timing cyc %0d: deck,small got %b", c, {deck_add, small_add});
            end
         end
         if (c == 0)  btn[3] = 1'b1;
         if (c == 3)  btn[2] = 1'b1;
         if (c == 30) btn = '0;
         if (c == 50) btn[2] = 1'b1;
         if (c == 75) btn[2] = 1'b0;
      end
      vectors++;
      if (deck_n != 1 || small_n != 1 || err_n != 0) begin
         miscompares++;
         $display("FAIL overlap count: deck %0d small %0d err %0d required 1 1 0", deck_n, small_n, err_n);
      end
   endtask

   task automatic test_reset_mid_hold();
      int pulses = 0;
      for (int c = 0; c < 75; c++) begin
         @(negedge clk);
         vectors++;
         if ({busy, multi_err, cmds} !== {m_hold, m_merr, m_cmd}) begin
            miscompares++;
            $display("FAIL reset_mid_hold model cyc %0d: got %b required %b", c, {busy, multi_err, cmds}, {m_hold, m_merr, m_cmd});
         end
         if (back) pulses++;
         if (c == 33) begin
            vectors++;
            if (back !== 1'b1) begin
               miscompares++;
               $display("FAIL reset_mid_hold refire: back got %b required 1 at cyc 33", back);
            end
         end
         if (c == 0) btn[4] = 1'b1;
         if (c == 20) begin
            rst = 1'b1;
            #1;
            vectors++;
            if ({busy, multi_err, cmds} !== 7'b0) begin
               miscompares++;
               $display("FAIL reset_mid_hold async: got %b required 0000000", {busy, multi_err, cmds});
            end
         end
         if (c == 22) rst = 1'b0;
         if (c == 45) btn[4] = 1'b0;
      end
      vectors++;
      if (pulses != 2) begin
         miscompares++;
         $display("FAIL reset_mid_hold count: got %0d back pulses required 2", pulses);
      end
   endtask

   task automatic test_glitch();
      int active = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         vectors++;
         if ({busy, multi_err, cmds} !== {m_hold, m_merr, m_cmd}) begin
            miscompares++;
            $display("FAIL glitch model cyc %0d: got %b required %b", c, {busy, multi_err, cmds}, {m_hold, m_merr, m_cmd});
         end
         if (busy || multi_err || cmds != '0) active++;
         btn[0] = (c < 7);
      end
      vectors++;
      if (active != 0) begin
         miscompares++;
         $display("FAIL glitch quiet: got %0d active cycles required 0", active);
      end
   endtask

   task automatic test_random();
      int hold_left = 0;
      int unsigned mode;
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         vectors++;
         if ({busy, multi_err, cmds} !== {m_hold, m_merr, m_cmd}) begin
            miscompares++;
            $display("FAIL random model cyc %0d: got %b required %b", c, {busy, multi_err, cmds}, {m_hold, m_merr, m_cmd});
         end
         if (!$onehot0({multi_err, cmds})) begin
            miscompares++;
            $display("FAIL random exclusive cyc %0d: got %b required at most one high", c, {multi_err, cmds});
         end
         if (hold_left == 0) begin
            mode = $urandom_range(0, 99);
            if (mode < 45)      btn = '0;
            else if (mode < 85) btn = 5'(1 << $urandom_range(0, 4));
            else                btn = 5'($urandom);
            hold_left = (mode < 70) ? int'($urandom_range(9, 30)) : int'($urandom_range(1, 8));
         end else begin
            hold_left--;
         end
      end
      btn = '0;
   endtask

   task automatic settle();
      btn = '0;
      repeat (30) @(negedge clk);
   endtask

   initial begin
      test_reset();
      settle();
      test_clean_press();
      settle();
      test_bounce();
      settle();
      test_simultaneous();
      settle();
      test_overlap();
      settle();
      test_reset_mid_hold();
      settle();
      test_glitch();
      settle();
      test_random();
      settle();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
